// File: rtl/fetch_instr_queue.sv
// Purpose : in-order instruction buffer between fetch and decode; compacts sparse fetch lanes, presents oldest DEQ_WIDTH entries.
// Latency : one cycle from enqueue to visibility on the dequeue lanes (no bypass); dequeue read is combinational.
// Backpressure: enq_ready_o from registered occupancy only (room for a full bundle); deq_num_i clamped to presented lanes.
//
// Ports:
//   clk_i, rst_ni                      clock / async active-low reset
//   flush_i                            drop every entry (wins over same-cycle enq/deq)
//   enq_valid_i/enq_ready_o            bundle handshake
//   enq_mask_i/enq_instr_i/enq_pc_i    per-lane valid, instruction and PC (lane k at [k*W +: W])
//   deq_valid_o/deq_instr_o/deq_pc_o   lane k = (k+1)-th oldest entry, zero when not valid
//   deq_num_i                          entries consumed this cycle
//   count_o                            registered occupancy
module fetch_instr_queue #(
    parameter int unsigned INSTR_PER_FETCH = 4,
    parameter int unsigned DEQ_WIDTH       = 4,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned ILEN            = 32,
    parameter int unsigned VLEN            = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            enq_valid_i,
    output logic                            enq_ready_o,
    input  logic [INSTR_PER_FETCH-1:0]      enq_mask_i,
    input  logic [INSTR_PER_FETCH*ILEN-1:0] enq_instr_i,
    input  logic [INSTR_PER_FETCH*VLEN-1:0] enq_pc_i,
    output logic [DEQ_WIDTH-1:0]            deq_valid_o,
    output logic [DEQ_WIDTH*ILEN-1:0]       deq_instr_o,
    output logic [DEQ_WIDTH*VLEN-1:0]       deq_pc_o,
    input  logic [$clog2(DEQ_WIDTH):0]      deq_num_i,
    output logic [$clog2(DEPTH):0]          count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - INSTR_PER_FETCH);
    localparam logic [CW-1:0] DEQ_W_C   = CW'(DEQ_WIDTH);

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [ILEN-1:0] instr_q [DEPTH];
    logic [VLEN-1:0] pc_q    [DEPTH];

    logic            enq_fire;
    logic [CW-1:0]   enq_n;
    logic [CW-1:0]   enq_n_eff;
    logic [PW-1:0]   wr_idx [INSTR_PER_FETCH];
    logic [CW-1:0]   deq_avail;
    logic [CW-1:0]   deq_req;
    logic [CW-1:0]   deq_n;

    assign enq_ready_o = (count_q <= READY_MAX);
    assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
    assign count_o     = count_q;

    // Compaction: each set lane lands at tail plus the number of set lanes below it,
    // so masked-off lanes leave no holes. Pointer arithmetic wraps modulo DEPTH.
    always_comb begin
        enq_n = '0;
        for (int k = 0; k < int'(INSTR_PER_FETCH); k++) begin
            wr_idx[k] = tail_q + enq_n[PW-1:0];
            enq_n     = enq_n + CW'(enq_mask_i[k]);
        end
    end

    assign enq_n_eff = enq_fire ? enq_n : '0;
    assign deq_avail = (count_q < DEQ_W_C) ? count_q : DEQ_W_C;
    assign deq_req   = CW'(deq_num_i);
    assign deq_n     = (deq_req < deq_avail) ? deq_req : deq_avail;

    always_comb begin
        head_d  = head_q + deq_n[PW-1:0];
        tail_d  = tail_q + enq_n_eff[PW-1:0];
        count_d = count_q + enq_n_eff - deq_n;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left untouched by flush; only the pointers are rewound.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (enq_fire) begin
            for (int k = 0; k < int'(INSTR_PER_FETCH); k++) begin
                if (enq_mask_i[k]) begin
                    instr_q[wr_idx[k]] <= enq_instr_i[k*ILEN +: ILEN];
                    pc_q[wr_idx[k]]    <= enq_pc_i[k*VLEN +: VLEN];
                end
            end
        end
    end

    for (genvar k = 0; k < int'(DEQ_WIDTH); k++) begin : g_deq
        logic [PW-1:0] rd_idx;
        assign rd_idx                      = head_q + PW'(k);
        assign deq_valid_o[k]              = (count_q > CW'(k));
        assign deq_instr_o[k*ILEN +: ILEN] = deq_valid_o[k] ? instr_q[rd_idx] : '0;
        assign deq_pc_o[k*VLEN +: VLEN]    = deq_valid_o[k] ? pc_q[rd_idx]    : '0;
    end

    // Consuming more lanes than are presented is a consumer bug; the clamp above keeps state sane.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !flush_i |-> (deq_req <= deq_avail));

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Parametrised in-order instruction buffer between the multi-instruction fetch stage (I-cache output) and decode/rename.
- Accepts up to INSTR_PER_FETCH instructions per cycle under a sparse slot mask and compacts them.
- Presents up to DEQ_WIDTH oldest instructions per cycle, each with its PC.
- Whole-queue flush on redirect.

Parameters:
- INSTR_PER_FETCH, 4, enqueue lanes per cycle (cfg_t.INSTR_PER_FETCH).
- DEQ_WIDTH, 4, dequeue lanes per cycle (matches NRET).
- DEPTH, 16, entries; power of two, ≥ 2*INSTR_PER_FETCH.
- ILEN, 32, instruction width in bits.
- VLEN, 32, PC width in bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all entries.
- enq_valid_i  in  1  fetch bundle valid.
- enq_ready_o  out  1  queue can accept a full bundle.
- enq_mask_i  in  INSTR_PER_FETCH  per-lane valid; may be non-contiguous.
- enq_instr_i  in  INSTR_PER_FETCH*ILEN  lane k at bits [k*ILEN +: ILEN].
- enq_pc_i  in  INSTR_PER_FETCH*VLEN  lane k PC.
- deq_valid_o  out  DEQ_WIDTH  lane k holds the (k+1)-th oldest entry.
- deq_instr_o  out  DEQ_WIDTH*ILEN  dequeue instructions.
- deq_pc_o  out  DEQ_WIDTH*VLEN  dequeue PCs.
- deq_num_i  in  $clog2(DEQ_WIDTH)+1  entries consumed this cycle.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: head_q, tail_q ($clog2(DEPTH) bits, modular wrap); count_q; storage arrays instr_q/pc_q [DEPTH].
- Reset (rst_ni low, asynchronous):
  - head_q, tail_q, count_q and storage cleared to 0.
  - Outputs during and after reset: deq_valid_o=0, deq_instr_o=0, deq_pc_o=0, count_o=0, enq_ready_o=1.
- enq_ready_o = (DEPTH − count_q) ≥ INSTR_PER_FETCH.
  - Computed from registered count only.
  - Same-cycle dequeue does not raise ready.
  - Does not depend on enq_valid_i.
- Enqueue fires when enq_valid_i && enq_ready_o && !flush_i.
  - enq_n = popcount(enq_mask_i).
  - Set lanes are written in ascending lane order to tail_q, tail_q+1, …; masked-off lanes leave no holes.
  - tail_q += enq_n.
  - enq_valid_i with mask 0 is legal and a no-op.
- Dequeue (read is combinational, zero-latency):
  - deq_valid_o[k] = (count_q > k).
  - deq_instr_o/deq_pc_o lane k = storage[head_q+k].
  - Lanes with deq_valid_o low output 0.
- Consume: deq_n = min(deq_num_i, DEQ_WIDTH, count_q); head_q += deq_n.
  - deq_num_i > popcount(deq_valid_o) is a protocol error: clamp, plus simulation assertion.
- No bypass: an enqueued entry first appears on the dequeue lanes the cycle after the write.
- Same-cycle enqueue and dequeue: count_q' = count_q + enq_n − deq_n. The ready rule guarantees no overflow.
- Pointer wrap: a bundle straddling index DEPTH−1 → 0 is split; order is preserved through wrap.
- flush_i has priority over same-cycle enq/deq.
  - Next cycle: head_q=tail_q=0, count_q=0. Storage is not cleared.
  - That cycle's enqueue bundle is dropped; its deq_num_i is ignored.
- Full: count_q > DEPTH−INSTR_PER_FETCH deasserts enq_ready_o even when some slots are free.
- Empty: all deq_valid_o = 0 and deq_num_i is ignored.
- count_o = count_q (registered).

Test Plan:
- Reset, then enqueue mask 4'b1111 with PCs 0x100/104/108/10C:
  - Next cycle deq_valid_o=4'b1111, lane 0 PC 0x100, count_o=4.
  - deq_num_i=4 → count_o=0 the following cycle.
- Sparse mask 4'b0110 with lane PCs 0x204/0x208:
  - Next cycle deq_valid_o=4'b0011, lane 0 PC 0x204, lane 1 PC 0x208.
- Fill to 13 entries:
  - enq_ready_o=0.
  - deq_num_i=1 → count 12 next cycle, enq_ready_o=1.
  - At count 12, simultaneous enqueue of 4 and dequeue of 4 → count stays 12.
- Wrap: drive tail_q to 14, enqueue 4 (PCs 0x300–0x30C), drain in order:
  - PCs emerge 0x300, 0x304, 0x308, 0x30C; tail_q ends at 2.
- Flush with enq_valid_i=1 and deq_num_i=2 at count 9:
  - Next cycle count_o=0, deq_valid_o=0; the enqueued bundle is absent.
- Assert rst_ni low mid-stream at count 7, asynchronously between edges:
  - Outputs go to reset values immediately; after release an enqueue of 1 yields count_o=1.
